// File: rtl/sbox_substitution_if.sv
// ---------------------------------------------------------------------------
// sbox_substitution_if
// Handshake bundle between the DES round logic and the S-box back end.
//   in_valid / in_ready : operand handshake (producer -> block)
//   RE_48bit            : 48-bit expanded right half, bit 47 = DES bit 1
//   subkey              : 48-bit round subkey, bit 47 = DES bit 1
//   out_valid / out_ready : result handshake (block -> consumer)
//   f_out               : 32-bit f(R,K) result, bit 31 = DES bit 1
// Modports:
//   master : the round logic side (drives operands, accepts results)
//   slave  : the sbox_substitution block
// ---------------------------------------------------------------------------
interface sbox_substitution_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] RE_48bit;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;

  modport master (
    output in_valid, RE_48bit, subkey, out_ready,
    input  in_ready, out_valid, f_out
  );

  modport slave (
    input  in_valid, RE_48bit, subkey, out_ready,
    output in_ready, out_valid, f_out
  );
endinterface

// File: rtl/sbox_substitution.sv
// ---------------------------------------------------------------------------
// sbox_substitution
// DES f-function back end. Captures X = RE_48bit ^ subkey, then walks X
// through S1..S8, BOXES_PER_CYCLE boxes per clock, packing the 4-bit
// results into a 32-bit word. The result is presented with a valid/ready
// handshake and held until the consumer takes it.
//
// Parameters:
//   BOXES_PER_CYCLE : S-boxes evaluated per clock (1, 2, 4 or 8);
//                     a job takes N = 8/BOXES_PER_CYCLE substitution cycles.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   io    : sbox_substitution_if.slave (operand and result handshakes)
// Configuration macro:
//   PBOX_EN : when defined, f_out carries P(S1..S8); otherwise f_out is the
//             raw S1..S8 concatenation and P is applied by the round logic.
// ---------------------------------------------------------------------------
module sbox_substitution #(
  parameter int BOXES_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sbox_substitution_if.slave    io
);

  localparam int N        = 8 / BOXES_PER_CYCLE;
  localparam int LANE_IN  = 6 * BOXES_PER_CYCLE;   // X bits consumed per cycle
  localparam int LANE_OUT = 4 * BOXES_PER_CYCLE;   // result bits produced per cycle
  localparam int LOG2B    = (BOXES_PER_CYCLE == 8) ? 3 :
                            (BOXES_PER_CYCLE == 4) ? 2 :
                            (BOXES_PER_CYCLE == 2) ? 1 : 0;
  localparam logic [2:0] LAST_CNT = 3'(N - 1);

  if (!(BOXES_PER_CYCLE == 1 || BOXES_PER_CYCLE == 2 ||
        BOXES_PER_CYCLE == 4 || BOXES_PER_CYCLE == 8)) begin : g_bad_boxes
    $error("sbox_substitution: BOXES_PER_CYCLE must be 1, 2, 4 or 8");
  end

  // S-box tables: 64 nibbles each, entry (row*16 + col) with entry 0 in the
  // most significant nibble, so each hex string reads like the printed table.
  localparam logic [255:0] S1_TAB = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2_TAB = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3_TAB = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4_TAB = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5_TAB = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6_TAB = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7_TAB = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8_TAB = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  // One S-box lookup: box selects S1..S8 (0..7), six is the 6-bit group.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
    logic [255:0] tbl;
    logic [5:0]   idx;
    logic [7:0]   bit_pos;
    case (box)
      3'd0:    tbl = S1_TAB;
      3'd1:    tbl = S2_TAB;
      3'd2:    tbl = S3_TAB;
      3'd3:    tbl = S4_TAB;
      3'd4:    tbl = S5_TAB;
      3'd5:    tbl = S6_TAB;
      3'd6:    tbl = S7_TAB;
      3'd7:    tbl = S8_TAB;
      default: tbl = S1_TAB;
    endcase
    // Row = {b5,b0}, column = b4..b1, so row*16+col is a bit shuffle.
    idx     = {six[5], six[0], six[4:1]};
    bit_pos = 8'd255 - {idx, 2'b00};
    return tbl[bit_pos -: 4];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [47:0] x_reg, x_next;
  logic [31:0] acc_reg, acc_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] f_out_reg, f_out_next;
  logic        out_valid_reg, out_valid_next;

  logic [LANE_OUT-1:0] sub_bits;
  logic [31:0]         acc_shift;
  logic [31:0]         f_load;

  genvar gi;

  // Lane gi always looks at the gi-th group from the top of X; the shifted
  // counter supplies the upper box-number bits so each lane hits the right
  // table (e.g. with 2 lanes: cycle 0 -> S1,S2, cycle 1 -> S3,S4, ...).
  for (gi = 0; gi < BOXES_PER_CYCLE; gi++) begin : g_lane
    logic [5:0] six;
    logic [2:0] box_sel;
    assign six     = x_reg[47 - 6*gi -: 6];
    assign box_sel = (cnt_reg << LOG2B) | 3'(gi);
    assign sub_bits[LANE_OUT - 1 - 4*gi -: 4] = sbox_lookup(box_sel, six);
  end

  // Results enter from the LSB side, so after N cycles S1 sits in [31:28].
  // With 8 lanes the shift clears the accumulator entirely.
  assign acc_shift = (acc_reg << LANE_OUT) | 32'(sub_bits);

`ifdef PBOX_EN
  // DES P permutation: output DES bit k takes input DES bit P_TAB[k-1].
  localparam int P_TAB [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                 1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9,
                                19, 13, 30,  6, 22, 11,  4, 25};
  for (gi = 0; gi < 32; gi++) begin : g_pbox
    assign f_load[31 - gi] = acc_shift[32 - P_TAB[gi]];
  end
`else
  assign f_load = acc_shift;
`endif

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    f_out_next     = f_out_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (io.in_valid) begin
          x_next     = io.RE_48bit ^ io.subkey;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = SUB;
        end
      end
      SUB: begin
        x_next   = x_reg << LANE_IN;
        acc_next = acc_shift;
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == LAST_CNT) begin
          f_out_next     = f_load;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        // No handover in the same edge: IDLE must be visited for a cycle.
        if (io.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      f_out_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      f_out_reg     <= f_out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign io.in_ready  = (state_reg == IDLE);
  assign io.out_valid = out_valid_reg;
  assign io.f_out     = f_out_reg;

endmodule

// File: tb/tb_sbox_substitution.sv
// ---------------------------------------------------------------------------
// tb_sbox_substitution
// Drives four sbox_substitution instances (BOXES_PER_CYCLE = 1, 2, 4, 8)
// with one shared operand stream and compares every result, latency and
// handshake state against a table-driven reference of the DES f back end.
// Honours PBOX_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sbox_substitution;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] re_in;
  logic [47:0] key_in;

  logic [3:0]  ov;
  logic [3:0]  ir;
  logic [31:0] fo [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : lane
    sbox_substitution_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.RE_48bit  = re_in;
    assign bus.subkey    = key_in;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign fo[g] = bus.f_out;
    sbox_substitution #(.BOXES_PER_CYCLE(1 << g)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .io    (bus.slave)
    );
  end

  // Reference tables in the printed FIPS 46-3 layout: [box][row*16 + col].
  localparam int SB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  localparam int PT [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                              1, 15, 23, 26,  5, 18, 31, 10,
                              2,  8, 24, 14, 32, 27,  3,  9,
                             19, 13, 30,  6, 22, 11,  4, 25};

  // Reference f back end: S-box substitution of RE ^ K, optionally permuted.
  function automatic logic [31:0] ref_f(input logic [47:0] re, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] f;
    x = re ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      int grp, row, col;
      grp = int'((x >> (42 - 6 * i)) & 48'd63);
      row = ((grp / 32) % 2) * 2 + (grp % 2);
      col = (grp / 2) % 16;
      s = (s << 4) | 32'(SB[i][row * 16 + col]);
    end
`ifdef PBOX_EN
    f = '0;
    for (int k2 = 0; k2 < 32; k2++) f[31 - k2] = s[32 - PT[k2]];
`else
    f = s;
`endif
    return f;
  endfunction

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and let the accepting edge pass; in_valid stays up
  // only when hold is set.
  task automatic start(input logic [47:0] re, input logic [47:0] k, input bit hold);
    re_in    = re;
    key_in   = k;
    in_valid = 1'b1;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  // Called right after the accepting edge (counted as edge 1): records the
  // edge at which each lane raises out_valid and checks result and latency.
  task automatic wait_all(input string tag, input logic [31:0] exp);
    int lat [4];
    for (int g = 0; g < 4; g++) lat[g] = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e > 1) tick();
      for (int g = 0; g < 4; g++) if (lat[g] == 0 && ov[g]) lat[g] = e;
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_lat_b%0d", tag, 1 << g), 32'(lat[g]), 32'(8 / (1 << g) + 1));
      chk($sformatf("%s_fout_b%0d", tag, 1 << g), fo[g], exp);
      $display("txn %s b=%0d f_out=0x%08h exp=0x%08h lat=%0d", tag, 1 << g, fo[g], exp, lat[g]);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_inready_b%0d", tag, 1 << g), 32'(ir[g]), 32'd1);
      chk($sformatf("%s_outvalid_b%0d", tag, 1 << g), 32'(ov[g]), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_inready_b%0d", tag, 1 << g), 32'(ir[g]), 32'd1);
      chk($sformatf("%s_outvalid_b%0d", tag, 1 << g), 32'(ov[g]), 32'd0);
      chk($sformatf("%s_fout_b%0d", tag, 1 << g), fo[g], 32'd0);
    end
  endtask

`ifdef PBOX_EN
  localparam logic [31:0] FIPS_EXP = 32'h234AA9BB;
`else
  localparam logic [31:0] FIPS_EXP = 32'h5C82B597;
`endif

  initial begin
    logic [31:0] zero_exp;
    logic [31:0] held [4];
    logic [47:0] a, b, ga, gb;

`ifdef PBOX_EN
    zero_exp = ref_f(48'd0, 48'd0);
`else
    zero_exp = 32'hEFA72C4D;
`endif

    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    re_in     = '0;
    key_in    = '0;

    // Reset release, idle
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    check_reset_outputs("rst");
    tick();
    check_reset_outputs("idle");

    // Zero vector
    start(48'd0, 48'd0, 1'b0);
    wait_all("zero", zero_exp);
    release_out("zero_rel");

    // FIPS round-1 vector, then backpressure while in DONE
    start(48'h7A15557A1555, 48'h1B02EFFC7072, 1'b0);
    wait_all("fips", FIPS_EXP);
    for (int g = 0; g < 4; g++) held[g] = fo[g];
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("bp%0d_outvalid_b%0d", c, 1 << g), 32'(ov[g]), 32'd1);
        chk($sformatf("bp%0d_fout_b%0d", c, 1 << g), fo[g], held[g]);
        chk($sformatf("bp%0d_inready_b%0d", c, 1 << g), 32'(ir[g]), 32'd0);
      end
    end
    release_out("fips_rel");

    // Random operands
    for (int t = 0; t < 6; t++) begin
      a = rnd48();
      b = rnd48();
      start(a, b, 1'b0);
      wait_all($sformatf("rnd%0d", t), ref_f(a, b));
      release_out($sformatf("rnd%0d_rel", t));
    end

    // Busy ignore, then no same-edge handover while in_valid stays high
    a  = rnd48();
    b  = rnd48();
    start(a, b, 1'b1);
    ga = rnd48();
    gb = rnd48();
    re_in  = ga;
    key_in = gb;
    wait_all("busy", ref_f(a, b));
    release_out("busy_rel");
    tick();
    for (int g = 0; g < 4; g++)
      chk($sformatf("handover_accept_b%0d", 1 << g), 32'(ir[g]), 32'd0);
    in_valid = 1'b0;
    wait_all("second", ref_f(ga, gb));
    release_out("second_rel");

    // Asynchronous reset in the middle of SUB (cnt = 3 on the 1-box lane)
    a = rnd48();
    b = rnd48();
    start(a, b, 1'b0);
    repeat (3) tick();
    #2 n_rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    check_reset_outputs("post_rst");

    start(48'd0, 48'd0, 1'b0);
    wait_all("zero_again", zero_exp);
    release_out("zero_again_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
